// File: rtl/print_sequencer_pkg.sv
// Shared types and constants for the print-string sequencer.
package print_sequencer_pkg;

   // Controller states, in the order a string is serviced.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      EMIT    = 3'd2,
      NEWLINE = 3'd3,
      FIN     = 3'd4
   } state_e;

   localparam logic [7:0] CHAR_NL  = 8'h0A;
   localparam logic [7:0] CHAR_NUL = 8'h00;

endpackage

// File: rtl/print_sequencer_byte_sel.sv
// Picks one byte lane out of a fetched word and flags the string terminator.
module print_sequencer_byte_sel
   import print_sequencer_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   output logic [7:0]  byte_o,
   output logic        is_nul_o
);

   // Lane 0 is the lowest-addressed byte (little-endian string layout).
   always_comb begin
      byte_o   = word_i[8*lane_i +: 8];
      is_nul_o = (byte_o == CHAR_NUL);
   end

endmodule

// File: rtl/print_sequencer.sv
// Print-string controller: fetches words of a NUL-terminated string and
// streams its bytes out one character at a time, with an optional newline.
module print_sequencer
   import print_sequencer_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MAX_WORDS = 256,
   parameter bit EMIT_NL   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              char_valid,
   output logic [7:0]        char_data,
   input  logic              char_ready,
   output logic [15:0]       char_count
);

   localparam int WCNT_W = $clog2(MAX_WORDS + 1);

   // State after the last character of a string (terminator or abort).
   localparam state_e TAIL_ST = EMIT_NL ? NEWLINE : FIN;

   state_e            state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [31:0]       word_q, word_d;
   logic [15:0]       count_q, count_d;
   logic              err_q, err_d;

   logic [7:0]        cur_byte;
   logic              cur_nul;

   print_sequencer_byte_sel u_byte_sel (
      .word_i   (word_q),
      .lane_i   (lane_q),
      .byte_o   (cur_byte),
      .is_nul_o (cur_nul)
   );

   // Status flags follow directly from the registered state.
   assign busy       = (state_q != IDLE);
   assign err        = err_q;
   assign mem_addr   = addr_q;
   assign char_count = count_q;

   // State and datapath registers; reset discards any partial string.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lane_q  <= 2'd0;
         addr_q  <= '0;
         wcnt_q  <= '0;
         word_q  <= 32'h0;
         count_q <= 16'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         word_q  <= word_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic and Moore/Mealy outputs of the sequencer.
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      addr_d     = addr_q;
      wcnt_d     = wcnt_q;
      word_d     = word_q;
      count_d    = count_q;
      err_d      = err_q;
      mem_req    = 1'b0;
      char_valid = 1'b0;
      char_data  = 8'h00;
      done       = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               lane_d  = start_addr[1:0];
               addr_d  = {start_addr[ADDR_W-1:2], 2'b00};
               wcnt_d  = '0;
               count_d = 16'h0;
               err_d   = 1'b0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               word_d  = mem_rdata;
               wcnt_d  = wcnt_q + WCNT_W'(1);
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (cur_nul) begin
               // Terminator itself is never sent to the sink.
               state_d = TAIL_ST;
            end else begin
               char_valid = 1'b1;
               char_data  = cur_byte;
               if (char_ready) begin
                  if (count_q != 16'hFFFF) begin
                     count_d = count_q + 16'd1;
                  end
                  if (lane_q != 2'd3) begin
                     lane_d = lane_q + 2'd1;
                  end else if (wcnt_q == WCNT_W'(MAX_WORDS)) begin
                     // Fetch budget spent without a terminator.
                     err_d   = 1'b1;
                     state_d = TAIL_ST;
                  end else begin
                     lane_d  = 2'd0;
                     addr_d  = addr_q + ADDR_W'(4);
                     state_d = FETCH;
                  end
               end
            end
         end
         NEWLINE: begin
            char_valid = 1'b1;
            char_data  = CHAR_NL;
            if (char_ready) begin
               state_d = FIN;
            end
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_print_sequencer.sv
// Randomized scoreboard bench for print_sequencer with a byte-walking reference model.
module tb_print_sequencer;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] start_addr = 32'h0;
   logic        busy, done, err, mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready = 1'b0;
   logic [15:0] char_count;

   print_sequencer #(.ADDR_W(32), .MAX_WORDS(MAXW), .EMIT_NL(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .char_valid (char_valid),
      .char_data  (char_data),
      .char_ready (char_ready),
      .char_count (char_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem_w [64];
   logic [7:0]  exp_char_q [$];
   logic [31:0] exp_addr_q [$];
   int          exp_cnt_q  [$];
   bit          exp_err_q  [$];

   int ready_pct = 100;
   int ack_max   = 0;
   bit spurious  = 1'b0;
   int stall_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got unexpected event expected none", name);
   endtask

   // Reference: walk the string byte by byte from start_addr through at most
   // MAXW aligned words; stop at NUL, otherwise abort with err.
   task automatic model(input logic [31:0] sa);
      logic [31:0] base, a;
      logic [7:0]  b;
      int k, n, nw;
      bit found;
      base  = {sa[31:2], 2'b00};
      k     = int'(sa[1:0]);
      n     = 0;
      found = 1'b0;
      while (k < 4*MAXW) begin
         a = base + 32'(k);
         b = mem_w[a[7:2]][8*a[1:0] +: 8];
         if (b == 8'h00) begin
            found = 1'b1;
            break;
         end
         exp_char_q.push_back(b);
         n++;
         k++;
      end
      nw = found ? (k / 4 + 1) : MAXW;
      for (int w = 0; w < nw; w++) exp_addr_q.push_back(base + 32'(4*w));
      exp_char_q.push_back(8'h0A);
      exp_cnt_q.push_back(n);
      exp_err_q.push_back(!found);
   endtask

   // Memory responder, character sink and output monitor.
   initial begin
      int wait_left;
      logic [31:0] pend_addr;
      bit prev_hold;
      logic [7:0] prev_data;
      wait_left = -1;
      pend_addr = 32'h0;
      prev_hold = 1'b0;
      prev_data = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mem_ack    = 1'b0;
            wait_left  = -1;
            prev_hold  = 1'b0;
            char_ready = 1'b0;
            continue;
         end
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req) begin
            if (wait_left < 0) begin
               wait_left = $urandom_range(0, ack_max);
               pend_addr = mem_addr;
            end else begin
               check("addr_stable", mem_addr, pend_addr);
            end
            if (wait_left == 0) begin
               if (exp_addr_q.size() == 0) fail_now("extra_fetch");
               else check("fetch_addr", mem_addr, exp_addr_q.pop_front());
               mem_rdata = mem_w[mem_addr[7:2]];
               mem_ack   = 1'b1;
               wait_left = -1;
            end else begin
               wait_left--;
            end
         end else begin
            if (wait_left >= 0) begin
               fail_now("req_dropped");
               wait_left = -1;
            end
            if (spurious && $urandom_range(0, 7) == 0) begin
               mem_ack   = 1'b1;
               mem_rdata = $urandom;
            end
         end

         if (prev_hold) begin
            check("hold_valid", 32'(char_valid), 32'd1);
            check("hold_data", 32'(char_data), 32'(prev_data));
         end
         if (stall_left > 0) begin
            char_ready = 1'b0;
            stall_left--;
         end else begin
            char_ready = ($urandom_range(0, 99) < ready_pct);
         end
         if (char_valid && char_ready) begin
            if (exp_char_q.size() == 0) fail_now("extra_char");
            else check("char", 32'(char_data), 32'(exp_char_q.pop_front()));
         end
         prev_hold = char_valid && !char_ready;
         prev_data = char_data;

         if (done) begin
            if (exp_cnt_q.size() == 0) begin
               fail_now("extra_done");
            end else begin
               check("err", 32'(err), 32'(exp_err_q.pop_front()));
               check("char_count", 32'(char_count), 32'(exp_cnt_q.pop_front()));
               check("busy_at_done", 32'(busy), 32'd1);
               check("chars_left", 32'(exp_char_q.size()), 32'd0);
               check("fetches_left", 32'(exp_addr_q.size()), 32'd0);
            end
         end
      end
   end

   task automatic clear_exp();
      exp_char_q.delete();
      exp_addr_q.delete();
      exp_cnt_q.delete();
      exp_err_q.delete();
   endtask

   task automatic check_reset_vals();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_char_valid", 32'(char_valid), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_char_data", 32'(char_data), 32'd0);
      check("rst_char_count", 32'(char_count), 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      clear_exp();
      start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Issue one string; optionally inject ignored starts and a sink stall.
   task automatic run_str(input logic [31:0] sa, input bit inject, input bit stall, output int cyc);
      model(sa);
      @(negedge clk);
      start_addr = sa;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("req_latency", 32'(mem_req), 32'd1);
      cyc = 1;
      forever begin
         @(negedge clk);
         cyc++;
         if (done || cyc >= 3000) break;
         if (stall && cyc == 4) stall_left = 5;
         start = inject && ($urandom_range(0, 9) == 0);
         if (start) start_addr = $urandom;
      end
      start = 1'b0;
      if (!done) begin
         fail_now("done_timeout");
         do_reset();
      end
      @(negedge clk);
   endtask

   initial begin
      int cyc;
      for (int i = 0; i < 64; i++) mem_w[i] = 32'h0;
      #1 rst_n = 1'b0;
      #2 check_reset_vals();
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // "Hi!" with zero-wait memory and sink: done seven cycles after start.
      mem_w[0] = 32'h0021_6948;
      run_str(32'h0000_0100, 1'b0, 1'b0, cyc);
      check("zero_wait_cycles", 32'(cyc), 32'd7);

      // Unaligned start skips the low lanes of the first word.
      mem_w[0] = 32'h6261_AAAA;
      mem_w[1] = 32'h0000_0063;
      run_str(32'h0000_0102, 1'b0, 1'b0, cyc);

      // Sink stalls mid-string.
      mem_w[4] = 32'h6463_6261;
      mem_w[5] = 32'h0000_6665;
      run_str(32'h0000_0110, 1'b0, 1'b1, cyc);

      // NUL as first byte: only the newline.
      mem_w[8] = 32'h4100_0000;
      run_str(32'h0000_0020, 1'b0, 1'b0, cyc);

      // No terminator within the fetch budget: abort with err.
      for (int i = 0; i < 4; i++) mem_w[i] = 32'h4141_4141;
      run_str(32'h0000_0200, 1'b0, 1'b0, cyc);

      // Same string with delayed acks and spurious acks outside fetch.
      ack_max = 3;
      spurious = 1'b1;
      mem_w[0] = 32'h0021_6948;
      run_str(32'h0000_0100, 1'b1, 1'b0, cyc);

      // Reset in the middle of emitting, then a clean string.
      for (int i = 0; i < 4; i++) mem_w[i] = 32'h4141_4141;
      model(32'h0000_0000);
      @(negedge clk);
      start_addr = 32'h0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      do_reset();
      mem_w[0] = 32'h0021_6948;
      run_str(32'h0000_0100, 1'b1, 1'b0, cyc);

      // Randomized strings, random sink/memory timing, address wrap.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] sa;
         for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            for (int j = 0; j < 4; j++)
               w[8*j +: 8] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            mem_w[i] = w;
         end
         ready_pct = $urandom_range(40, 100);
         ack_max   = $urandom_range(0, 3);
         sa = (t % 4 == 3) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
         run_str(sa, 1'b1, (t % 5 == 0), cyc);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
